// File: rtl/conv_enc_if.sv
// Handshake bundle for the rate-1/2 convolutional encoder.
// The encoder takes the slave side; the bit source and symbol sink take the master side.
interface conv_enc_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_sym;
    logic       out_last;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_last
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_last
    );
endinterface

// File: rtl/conv_enc.sv
// Rate-1/2 convolutional encoder with zero-tail frame termination.
// Bits in and {p1,p0} symbols out over valid/ready; every frame ends in trellis state 0.
module conv_enc #(
    parameter int unsigned    K  = 4,
    parameter logic [K-1:0]   G0 = 4'b1111,
    parameter logic [K-1:0]   G1 = 4'b1101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    conv_enc_if.slave   bus
);

    localparam int unsigned SW = K - 1;
    localparam int unsigned CW = $clog2(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sr_q, sr_d;
    logic [CW-1:0]   tail_cnt_q, tail_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [1:0]      out_sym_q, out_sym_d;
    logic            out_last_q, out_last_d;

    logic            slot_free;
    logic            in_ready_c;
    logic            in_acc;
    logic            tail_load;
    logic            last_tail;
    logic            enc_bit;
    logic [K-1:0]    v;
    logic            p0;
    logic            p1;

    // Handshake qualifiers and parity of the bit being loaded this cycle
    always_comb begin
        slot_free  = !out_valid_q || bus.out_ready;
        in_ready_c = enable && (state_q != TAIL) && slot_free;
        in_acc     = bus.in_valid && in_ready_c;
        tail_load  = enable && (state_q == TAIL) && slot_free;
        last_tail  = (tail_cnt_q == CW'(K - 2));
        enc_bit    = (state_q == TAIL) ? 1'b0 : bus.in_bit;
        v          = {enc_bit, sr_q};
        p0         = ^(v & G0);
        p1         = ^(v & G1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            tail_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            tail_cnt_q  <= tail_cnt_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next state: everything holds unless a symbol loads or the slot drains
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        tail_cnt_d  = tail_cnt_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;

        if (!enable) begin
            state_d     = IDLE;
            sr_d        = '0;
            tail_cnt_d  = '0;
            out_valid_d = 1'b0;
            out_sym_d   = 2'b00;
            out_last_d  = 1'b0;
        end else begin
            if (in_acc || tail_load) begin
                out_valid_d = 1'b1;
                out_sym_d   = {p1, p0};
                out_last_d  = tail_load && last_tail;
                sr_d        = {enc_bit, sr_q[SW-1:1]};
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end

            unique case (state_q)
                IDLE, DATA: begin
                    if (in_acc) begin
                        if (bus.in_last) begin
                            state_d    = TAIL;
                            tail_cnt_d = '0;
                        end else begin
                            state_d    = DATA;
                        end
                    end
                end
                TAIL: begin
                    if (tail_load) begin
                        if (last_tail) begin
                            state_d    = IDLE;
                            tail_cnt_d = '0;
                        end else begin
                            tail_cnt_d = tail_cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sym   = out_sym_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_conv_enc.sv
// Scoreboard bench for conv_enc: a shift-register model queues expected {last,sym}
// when bits are accepted; a negedge monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_conv_enc;

    logic clk;
    logic rst;
    logic enable;
    int   n_chk;
    int   n_pass;
    int   ready_mode;

    logic       m1, m2, m3;
    logic [2:0] exp_q[$];
    logic [1:0] exp1 [7];

    conv_enc_if bus ();

    conv_enc dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Encoder reference: m1 is the newest stored bit; octal 17 taps all, octal 15 skips m2
    task automatic push_sym(input logic b, input logic last);
        logic p0, p1;
        p0 = b ^ m1 ^ m2 ^ m3;
        p1 = b ^ m1 ^ m3;
        m3 = m2;
        m2 = m1;
        m1 = b;
        exp_q.push_back({last, p1, p0});
    endtask

    task automatic model_clear();
        m1 = 1'b0;
        m2 = 1'b0;
        m3 = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n, input bit last,
                              input bit tails, input bit hold, output int stall0);
        stall0 = 0;
        for (int i = 0; i < n; i++) begin
            int waited;
            bit ok;
            waited = 0;
            ok     = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_bit   = bits[i];
            bus.in_last  = last && (i == n - 1);
            while (!ok && waited < 200) begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk);
                if (!ok) waited++;
            end
            if (i == 0) stall0 = waited;
            if (!ok) begin
                chk("accept_timeout", 32'(waited), 32'd0);
                bus.in_valid = 1'b0;
                return;
            end
            push_sym(bits[i], 1'b0);
            if (bus.in_last && tails) begin
                push_sym(1'b0, 1'b0);
                push_sym(1'b0, 1'b0);
                push_sym(1'b0, 1'b1);
            end
            #1;
        end
        if (!hold) begin
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Sink readiness pattern: steady, alternating, or random
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: compare each handshake against the scoreboard and check stall stability
    initial begin
        logic       prev_stall;
        logic [2:0] prev;
        logic [2:0] e;
        prev_stall = 1'b0;
        prev       = 3'b000;
        forever begin
            @(negedge clk);
            if (prev_stall)
                chk("stall_hold", 32'({bus.out_valid, bus.out_last, bus.out_sym}), 32'({1'b1, prev}));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sym", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sym", 32'(bus.out_sym), 32'(e[1:0]));
                    chk("last", 32'(bus.out_last), 32'(e[2]));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready && rst && enable;
            prev       = {bus.out_last, bus.out_sym};
        end
    end

    initial begin
        int s;
        int s2;
        n_chk        = 0;
        n_pass       = 0;
        ready_mode   = 0;
        rst          = 1'b0;
        enable       = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_last  = 1'b0;
        exp1 = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
        model_clear();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sym", 32'(bus.out_sym), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Frame 1,0,1,1 against literal symbols, plus in_ready low across the tail
        fork
            begin
                send_frame(16'b1101, 4, 1'b1, 1'b1, 1'b0, s);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("tail_in_ready", 32'(bus.in_ready), 32'd0);
                end
                @(negedge clk);
                chk("post_tail_in_ready", 32'(bus.in_ready), 32'd1);
            end
            begin
                int c;
                c = 0;
                while (!bus.out_valid && c < 20) begin
                    @(negedge clk);
                    c++;
                end
                for (int j = 0; j < 7; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("f1_valid", 32'(bus.out_valid), 32'd1);
                    chk("f1_sym", 32'(bus.out_sym), 32'(exp1[j]));
                    chk("f1_last", 32'(bus.out_last), (j == 6) ? 32'd1 : 32'd0);
                end
            end
        join
        wait_drain();

        // Single-bit frame, then the next frame waits exactly for the tail
        send_frame(16'b0, 1, 1'b1, 1'b1, 1'b1, s);
        chk("single_bit_stall", 32'(s), 32'd0);
        send_frame(16'b1101, 4, 1'b1, 1'b1, 1'b0, s2);
        chk("next_frame_wait", 32'(s2), 32'd3);
        wait_drain();

        // Alternating out_ready back-pressure
        ready_mode = 1;
        send_frame(16'b1101, 4, 1'b1, 1'b1, 1'b0, s);
        wait_drain();
        ready_mode = 0;
        @(posedge clk);
        #1;

        // Async reset after the 2nd bit drops the frame with no tail
        send_frame(16'b01, 2, 1'b0, 1'b0, 1'b0, s);
        rst = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        chk("rst_async_clear", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_tail_after_rst", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send_frame(16'b11, 2, 1'b1, 1'b1, 1'b0, s);
        wait_drain();

        // enable dropped for one cycle during the tail
        send_frame(16'b1101, 4, 1'b1, 1'b0, 1'b0, s);
        @(posedge clk);
        push_sym(1'b0, 1'b0);
        #1 enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        model_clear();
        @(negedge clk);
        chk("en_clear_valid", 32'(bus.out_valid), 32'd0);
        chk("en_idle_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("en_no_resume", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        send_frame(16'b1101, 4, 1'b1, 1'b1, 1'b0, s);
        wait_drain();

        // Back-to-back single-bit frames with in_valid held high
        send_frame(16'b1, 1, 1'b1, 1'b1, 1'b1, s);
        send_frame(16'b1, 1, 1'b1, 1'b1, 1'b0, s2);
        chk("b2b_tail_block", 32'(s2), 32'd3);
        wait_drain();

        // Random frames under random back-pressure
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            int unsigned n;
            logic [15:0] bits;
            n    = $urandom_range(1, 8);
            bits = 16'($urandom);
            send_frame(bits, int'(n), 1'b1, 1'b1, 1'b0, s);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
